// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The arbiter takes the slave view; requesters and memory drive the master view.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [31:0]       m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;

    logic              m1_req;
    logic              m1_we;
    logic [31:0]       m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;

    logic [31:0]       mem_address;
    logic [DATA_W-1:0] mem_writeData;
    logic              mem_memWrite;
    logic              mem_memRead;
    logic [DATA_W-1:0] mem_readData;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata, m1_err,
        output mem_address, mem_writeData, mem_memWrite, mem_memRead,
        input  mem_readData
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata, m1_err,
        input  mem_address, mem_writeData, mem_memWrite, mem_memRead,
        output mem_readData
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU
// port (m0) and the DMA/loader port (m1), with a bounded burst per owner and
// blocking of out-of-range word addresses.
//
// state | meaning
// IDLE  | no owner, memory side quiet
// OWN0  | m0 owns the memory, ack0 follows req0
// OWN1  | m1 owns the memory, ack1 follows req1
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 128,
    parameter int MAX_BURST = 4
) (
    input logic            clk,
    input logic            reset,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t            state, stateNext;
    logic              last, lastNext;
    logic [CNT_W-1:0]  cnt, cntNext;

    logic              who;
    logic              reqX, reqO, weX, inRange, errX;
    logic [31:0]       addrX;
    logic [DATA_W-1:0] wdataX, rdataX;

    // State, last-served master and burst count; last starts at 1 so m0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            last  <= lastNext;
            cnt   <= cntNext;
        end
    end

    // Owner mux, range check, memory-side drive and next-state selection.
    always_comb begin
        stateNext         = state;
        lastNext          = last;
        cntNext           = cnt;
        bus.m0_ack        = 1'b0;
        bus.m0_rdata      = '0;
        bus.m0_err        = 1'b0;
        bus.m1_ack        = 1'b0;
        bus.m1_rdata      = '0;
        bus.m1_err        = 1'b0;
        bus.mem_address   = '0;
        bus.mem_writeData = '0;
        bus.mem_memWrite  = 1'b0;
        bus.mem_memRead   = 1'b0;

        who     = (state == OWN1);
        reqX    = who ? bus.m1_req   : bus.m0_req;
        reqO    = who ? bus.m0_req   : bus.m1_req;
        weX     = who ? bus.m1_we    : bus.m0_we;
        addrX   = who ? bus.m1_addr  : bus.m0_addr;
        wdataX  = who ? bus.m1_wdata : bus.m0_wdata;
        inRange = (addrX < 32'(DEPTH));
        rdataX  = (reqX && inRange) ? bus.mem_readData : '0;
        errX    = reqX && !inRange;

        case (state)
            IDLE: begin
                if (bus.m0_req && (!bus.m1_req || last)) begin
                    stateNext = OWN0;
                    cntNext   = '0;
                end else if (bus.m1_req) begin
                    stateNext = OWN1;
                    cntNext   = '0;
                end
            end
            OWN0, OWN1: begin
                bus.mem_address   = addrX;
                bus.mem_writeData = wdataX;
                bus.mem_memWrite  = reqX && weX && inRange;
                bus.mem_memRead   = reqX && !weX && inRange;
                if (who) begin
                    bus.m1_ack   = reqX;
                    bus.m1_rdata = rdataX;
                    bus.m1_err   = errX;
                end else begin
                    bus.m0_ack   = reqX;
                    bus.m0_rdata = rdataX;
                    bus.m0_err   = errX;
                end

                if (!reqX) begin
                    // Owner let go without an access: hand over directly or go quiet.
                    if (reqO) begin
                        stateNext = who ? OWN0 : OWN1;
                        cntNext   = '0;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    lastNext = who;
                    if (reqO && (cnt == CNT_MAX)) begin
                        stateNext = who ? OWN0 : OWN1;
                        cntNext   = '0;
                    end else if (cnt != CNT_MAX) begin
                        cntNext = cnt + 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural memory, per-master expected-response
// queues filled at issue time and a negedge monitor that pops and compares on ack.
module tb_dmem_arbiter;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 128;
    localparam int MAX_BURST = 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   wrCount = 0;

    exp_t exp0q[$];
    exp_t exp1q[$];
    int   ackLog[$];

    logic [31:0] dmem[DEPTH];
    logic [31:0] refMem[DEPTH];

    dmem_arbiter_if #(.DATA_W(DATA_W)) bus();

    dmem_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory: commits on the rising edge, reads combinationally.
    always @(posedge clk) begin
        if (bus.mem_memWrite) dmem[bus.mem_address[6:0]] <= bus.mem_writeData;
    end
    assign bus.mem_readData = dmem[bus.mem_address[6:0]];

    // Monitor: scoreboard pops and bus-level checks, sampled away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        logic expWr, expRd;
        if (!reset) begin
            total++;
            if (bus.m0_ack && bus.m1_ack) begin
                bad++;
                $display("FAIL both_ack: m0_ack=%b m1_ack=%b, need at most one", bus.m0_ack, bus.m1_ack);
            end
            if (bus.m0_ack) begin
                ackLog.push_back(0);
                total++;
                if (exp0q.size() == 0) begin
                    bad++;
                    $display("FAIL m0_unexpected_ack: ack with nothing outstanding");
                end else begin
                    e = exp0q.pop_front();
                    if (bus.m0_rdata !== e.data || bus.m0_err !== e.err) begin
                        bad++;
                        $display("FAIL m0_resp: got rdata=%h err=%b, want rdata=%h err=%b",
                                 bus.m0_rdata, bus.m0_err, e.data, e.err);
                    end
                end
            end else begin
                total++;
                if (bus.m0_rdata !== '0 || bus.m0_err !== 1'b0) begin
                    bad++;
                    $display("FAIL m0_quiet: got rdata=%h err=%b, want 0 0", bus.m0_rdata, bus.m0_err);
                end
            end
            if (bus.m1_ack) begin
                ackLog.push_back(1);
                total++;
                if (exp1q.size() == 0) begin
                    bad++;
                    $display("FAIL m1_unexpected_ack: ack with nothing outstanding");
                end else begin
                    e = exp1q.pop_front();
                    if (bus.m1_rdata !== e.data || bus.m1_err !== e.err) begin
                        bad++;
                        $display("FAIL m1_resp: got rdata=%h err=%b, want rdata=%h err=%b",
                                 bus.m1_rdata, bus.m1_err, e.data, e.err);
                    end
                end
            end else begin
                total++;
                if (bus.m1_rdata !== '0 || bus.m1_err !== 1'b0) begin
                    bad++;
                    $display("FAIL m1_quiet: got rdata=%h err=%b, want 0 0", bus.m1_rdata, bus.m1_err);
                end
            end
            expWr = (bus.m0_ack && bus.m0_we && bus.m0_addr < DEPTH) ||
                    (bus.m1_ack && bus.m1_we && bus.m1_addr < DEPTH);
            expRd = (bus.m0_ack && !bus.m0_we && bus.m0_addr < DEPTH) ||
                    (bus.m1_ack && !bus.m1_we && bus.m1_addr < DEPTH);
            total++;
            if (bus.mem_memWrite !== expWr || bus.mem_memRead !== expRd) begin
                bad++;
                $display("FAIL mem_enables: got we=%b re=%b, want we=%b re=%b",
                         bus.mem_memWrite, bus.mem_memRead, expWr, expRd);
            end
            if (bus.mem_memWrite) wrCount++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Presents one access and returns after the rising edge that completes it; req stays high.
    task automatic issue(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, output int waited);
        exp_t e;
        int n;
        logic acked;
        e.err  = (addr >= DEPTH);
        e.data = e.err ? 32'h0 : refMem[addr[6:0]];
        if (we && !e.err) refMem[addr[6:0]] = wd;
        if (m == 0) begin
            exp0q.push_back(e);
            bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wd;
        end else begin
            exp1q.push_back(e);
            bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wd;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            acked = (m == 0) ? bus.m0_ack : bus.m1_ack;
        end while (!acked && n < 100);
        if (!acked) begin
            total++;
            bad++;
            $display("FAIL m%0d_ack_timeout: got no ack in %0d cycles, want ack", m, n);
            if (m == 0) void'(exp0q.pop_back()); else void'(exp1q.pop_back());
        end
        @(posedge clk);
        #1;
        waited = n - 1;
    endtask

    task automatic rel(input int m);
        if (m == 0) begin bus.m0_req = 1'b0; bus.m0_we = 1'b0; end
        else begin bus.m1_req = 1'b0; bus.m1_we = 1'b0; end
    endtask

    task automatic randMaster(input int m, input int base);
        int w;
        int g;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            g = $urandom_range(0, 3);
            if (g > 1) begin
                rel(m);
                repeat (g - 1) @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 7) == 0) a = 32'd128 + $urandom_range(0, 5000);
            else a = 32'(base + $urandom_range(0, 63));
            issue(m, 1'($urandom_range(0, 1)), a, $urandom, w);
        end
        rel(m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w, w1;
        int expLog[$];
        exp_t e;
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
        for (int i = 0; i < DEPTH; i++) begin
            dmem[i] = $urandom;
            refMem[i] = dmem[i];
        end
        dmem[5] = 32'hDEADBEEF;
        refMem[5] = 32'hDEADBEEF;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        check("reset_acks", {30'd0, bus.m0_ack, bus.m1_ack}, 32'd0);
        check("reset_mem_en", {30'd0, bus.mem_memWrite, bus.mem_memRead}, 32'd0);
        @(posedge clk);
        #1;

        // Single read with one-cycle grant latency.
        issue(0, 1'b0, 32'd5, 32'd0, w);
        rel(0);
        check("grant_latency", 32'(w), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Reset during an m1 write; data equals the current word so commit either way is harmless.
        e.data = refMem[70];
        e.err  = 1'b0;
        exp1q.push_back(e);
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'd70; bus.m1_wdata = refMem[70];
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_pre_ack", {31'd0, bus.m1_ack}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_acks", {30'd0, bus.m0_ack, bus.m1_ack}, 32'd0);
        check("rst_mem_en", {30'd0, bus.mem_memWrite, bus.mem_memRead}, 32'd0);
        rel(1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Tie after reset goes to m0 first, then m1.
        ackLog.delete();
        fork
            begin issue(0, 1'b0, 32'd10, 32'd0, w); rel(0); end
            begin issue(1, 1'b0, 32'd11, 32'd0, w1); rel(1); end
        join
        check("tie_count", 32'(ackLog.size()), 32'd2);
        if (ackLog.size() == 2) begin
            check("tie_first", 32'(ackLog[0]), 32'd0);
            check("tie_second", 32'(ackLog[1]), 32'd1);
        end
        repeat (2) @(posedge clk);
        #1;

        // m1 write then read back the same word.
        wrCount = 0;
        issue(1, 1'b1, 32'd3, 32'h12345678, w);
        rel(1);
        issue(1, 1'b0, 32'd3, 32'd0, w);
        rel(1);
        check("wr_cycles", 32'(wrCount), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Burst bound: m0 streams 10 reads while m1 waits for one access.
        ackLog.delete();
        fork
            begin
                for (int i = 0; i < 10; i++) issue(0, 1'b0, 32'(20 + i), 32'd0, w);
                rel(0);
            end
            begin issue(1, 1'b0, 32'd90, 32'd0, w1); rel(1); end
        join
        expLog.delete();
        for (int i = 0; i < 10; i++) begin
            if (i == MAX_BURST) expLog.push_back(1);
            expLog.push_back(0);
        end
        check("burst_len", 32'(ackLog.size()), 32'(expLog.size()));
        total++;
        if (ackLog != expLog) begin
            bad++;
            $display("FAIL burst_order: got %p, want %p", ackLog, expLog);
        end
        total++;
        if (w1 > MAX_BURST + 1) begin
            bad++;
            $display("FAIL burst_wait: got %0d cycles, want <= %0d", w1, MAX_BURST + 1);
        end
        repeat (2) @(posedge clk);
        #1;

        // Out-of-range write must be acked with err and never reach memory.
        wrCount = 0;
        issue(0, 1'b1, 32'd128, 32'hFFFFFFFF, w);
        rel(0);
        check("oor_no_write", 32'(wrCount), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Concurrent random traffic in disjoint halves of memory.
        fork
            randMaster(0, 0);
            randMaster(1, 64);
        join
        repeat (3) @(posedge clk);
        #1;

        // Read back every word.
        for (int i = 0; i < DEPTH; i++) issue(0, 1'b0, 32'(i), 32'd0, w);
        rel(0);
        repeat (3) @(posedge clk);
        #1;
        check("q0_drained", 32'(exp0q.size()), 32'd0);
        check("q1_drained", 32'(exp1q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
